// File: rtl/rv32i_types_pkg.sv
// Shared RV32I core types: machine word, fetch queue entry, fetch FSM states.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_VECTOR = 32'h0000_0200;

  typedef struct packed {
    word_t instr;
    word_t pc;
    logic  fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetch entries with flush; a flush may load one
// entry in the same cycle, which lands in slot 0.
module fetch_fifo
  import rv32i_types_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_idx;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_idx   = wr_ptr_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_idx   = '0;
      wr_ptr_d = push_i ? PW'(1) : '0;
      count_d  = push_i ? CW'(1) : '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_idx] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the PC, issues single outstanding word reads, queues
// returned words for decode and handles flushing redirects.
module ifetch_queue
  import rv32i_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  input  logic        instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   discard_addr_q, discard_addr_d;
  logic          fault_pend_q, fault_pend_d;

  logic          push, pop, full, empty;
  logic [CW-1:0] count, count_next;
  fetch_entry_t  push_data, head;

  assign pop = instr_valid && instr_ready;

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    discard_addr_d = discard_addr_q;
    fault_pend_d   = fault_pend_q;
    push           = 1'b0;
    push_data      = '0;
    imem_ren       = (state_q != FETCH_IDLE);
    imem_addr      = (state_q == FETCH_DISCARD) ? discard_addr_q : fetch_pc_q;

    if (redirect) begin
      fetch_pc_d   = redirect_pc;
      fault_pend_d = (redirect_pc[1:0] != 2'b00);
      if (fault_pend_d) begin
        push      = 1'b1;
        push_data = '{instr: '0, pc: redirect_pc, fault: 1'b1};
      end
    end else if (state_q == FETCH_WAIT && !imem_busy) begin
      push       = 1'b1;
      push_data  = '{instr: imem_rdata, pc: fetch_pc_q, fault: 1'b0};
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // Occupancy after this edge decides whether a new read may be started now.
    count_next = redirect ? CW'(push) : count + CW'(push) - CW'(pop);

    // A stalled read cannot be withdrawn: keep presenting its address until it
    // completes, then throw the data away.
    if (imem_ren && imem_busy && (redirect || state_q == FETCH_DISCARD)) begin
      state_d        = FETCH_DISCARD;
      discard_addr_d = imem_addr;
    end else if (imem_ren && imem_busy) begin
      state_d = FETCH_WAIT;
    end else if (count_next < CW'(DEPTH) && !fault_pend_d) begin
      state_d = FETCH_WAIT;
    end else begin
      state_d = FETCH_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= FETCH_IDLE;
      fetch_pc_q     <= RESET_PC;
      discard_addr_q <= '0;
      fault_pend_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      discard_addr_q <= discard_addr_d;
      fault_pend_q   <= fault_pend_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .flush_i    (redirect),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign instr_valid = !empty;
  assign instr       = empty ? '0 : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;
  assign instr_fault = empty ? 1'b0 : head.fault;

  push_not_full_a: assert property (@(posedge CLK) disable iff (!nRST)
    !(push && full && !pop && !redirect));

endmodule
